// File: rtl/rat_io_pkg.sv
// Shared definitions for the RAT MCU I/O bus blocks.
//   - port IDs decoded by the output controller (and future input IDs)
//   - scan state encoding for the 4-digit multiplexed display
//   - active-low segment/anode constants and the digit-enable helper
package rat_io_pkg;

  localparam logic [7:0] LEDS_ID    = 8'h40;
  localparam logic [7:0] SSEG_LO_ID = 8'h81;
  localparam logic [7:0] SSEG_HI_ID = 8'h82;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} scan_state_t;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;   // all cathodes off, dp off
  localparam logic       SEG_DP_OFF = 1'b1;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  // One-hot-low anode enable for a scan state; bit0 is the rightmost digit.
  function automatic logic [3:0] an_onehot(scan_state_t s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/rat_output_ctrl_if.sv
// MCU output write bus: one-cycle strobe with port address and data.
//   master: MCU side (drives), slave: peripheral side (receives).
interface rat_output_ctrl_if;
  logic       IO_STRB;
  logic [7:0] PORT_ID;
  logic [7:0] OUTPUT_DATA;

  modport master (output IO_STRB, output PORT_ID, output OUTPUT_DATA);
  modport slave  (input  IO_STRB, input  PORT_ID, input  OUTPUT_DATA);
endinterface

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to 7-segment decoder, active-low.
//   nib_i : 4-bit value 0..F
//   seg_o : cathodes g..a (bit6..bit0), 0 = lit
module sseg_hex_decode (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h7F;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end
endmodule

// File: rtl/rat_output_ctrl.sv
// RAT MCU output-port controller.
// Latches qualified bus writes into an LED register and a 16-bit display
// value, and scans the value onto a 4-digit active-low 7-segment display.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : MCU output write bus (IO_STRB, PORT_ID, OUTPUT_DATA)
//   LEDS     : latched LED value
//   SEGMENTS : registered cathodes, bit7 = dp, bits6..0 = g..a, active-low
//   ANODES   : registered digit enables, active-low, bit0 = rightmost
module rat_output_ctrl
  import rat_io_pkg::*;
#(
  parameter logic [7:0] P_LEDS_ID    = LEDS_ID,
  parameter logic [7:0] P_SSEG_LO_ID = SSEG_LO_ID,
  parameter logic [7:0] P_SSEG_HI_ID = SSEG_HI_ID,
  parameter int         REFRESH_DIV  = 100000,
  parameter int         BLANK_LZ     = 1
) (
  input  logic                CLK,
  input  logic                RST,
  rat_output_ctrl_if.slave    bus,
  output logic [7:0]          LEDS,
  output logic [7:0]          SEGMENTS,
  output logic [3:0]          ANODES
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [7:0]  led_q;
  logic [15:0] val_q;
  logic [CW-1:0] cnt_q;
  scan_state_t state_q;
  logic [3:0]  an_q;
  logic [7:0]  seg_q;

  logic [3:0]  nib;
  logic [6:0]  hex;
  logic        blank;
  logic [3:0]  an_d;
  logic [7:0]  seg_d;

  // Write capture; unmatched IDs and idle cycles hold every register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      led_q <= 8'h00;
      val_q <= 16'h0000;
    end else if (bus.IO_STRB) begin
      if (bus.PORT_ID == P_LEDS_ID)    led_q       <= bus.OUTPUT_DATA;
      if (bus.PORT_ID == P_SSEG_LO_ID) val_q[7:0]  <= bus.OUTPUT_DATA;
      if (bus.PORT_ID == P_SSEG_HI_ID) val_q[15:8] <= bus.OUTPUT_DATA;
    end
  end

  assign nib = val_q[{state_q, 2'b00} +: 4];

  sseg_hex_decode u_dec (
    .nib_i (nib),
    .seg_o (hex)
  );

  // Digit k>=1 goes dark when it and every digit above it are zero.
  always_comb begin
    blank = 1'b0;
    if (BLANK_LZ != 0) begin
      case (state_q)
        DIG1:    blank = (val_q[15:4]  == 12'h000);
        DIG2:    blank = (val_q[15:8]  == 8'h00);
        DIG3:    blank = (val_q[15:12] == 4'h0);
        default: blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    an_d  = blank ? AN_OFF    : an_onehot(state_q);
    seg_d = blank ? SEG_BLANK : {SEG_DP_OFF, hex};
  end

  // Scan FSM with registered display outputs; outputs lag state by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      state_q <= DIG0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        state_q <= scan_state_t'(state_q + 2'd1);
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign LEDS     = led_q;
  assign SEGMENTS = seg_q;
  assign ANODES   = an_q;

endmodule

// File: tb/tb_rat_output_ctrl.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor
// pops and compares. dut0 has blanking off, dut1 has blanking on.
module tb_rat_output_ctrl;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] LEDS0, SEG0, LEDS1, SEG1;
  logic [3:0] AN0, AN1;

  rat_output_ctrl_if bif();

  rat_output_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(0)) dut0 (
    .CLK(CLK), .RST(RST), .bus(bif), .LEDS(LEDS0), .SEGMENTS(SEG0), .ANODES(AN0));
  rat_output_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut1 (
    .CLK(CLK), .RST(RST), .bus(bif), .LEDS(LEDS1), .SEGMENTS(SEG1), .ANODES(AN1));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      nm;
    logic [7:0] leds;
    logic [3:0] an0, an1;
    logic [7:0] seg0, seg1;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  localparam logic [3:0] ANT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Reference model state
  logic [7:0]  m_led = 8'h00;
  logic [15:0] m_val = 16'h0000;
  int          m_n   = 0;

  task automatic disp(input bit blz, input logic [15:0] v, input int d,
                      output logic [3:0] an, output logic [7:0] seg);
    logic [15:0] hi;
    hi = v >> (4 * d);
    if (blz && d >= 1 && hi == 16'h0) begin
      an = 4'hF; seg = 8'hFF;
    end else begin
      an = ANT[d]; seg = HEX[hi[3:0]];
    end
  endtask

  task automatic tick(input string nm, input logic r, input logic s,
                      input logic [7:0] pid, input logic [7:0] dat);
    exp_t e;
    int d;
    RST = r; bif.IO_STRB = s; bif.PORT_ID = pid; bif.OUTPUT_DATA = dat;
    if (r) begin
      m_led = 8'h00; m_val = 16'h0000; m_n = 0;
      e.an0 = 4'hF; e.an1 = 4'hF; e.seg0 = 8'hFF; e.seg1 = 8'hFF;
    end else begin
      m_n++;
      d = ((m_n - 1) / 4) % 4;
      disp(1'b0, m_val, d, e.an0, e.seg0);
      disp(1'b1, m_val, d, e.an1, e.seg1);
      if (s) begin
        if (pid == 8'h40) m_led = dat;
        if (pid == 8'h81) m_val[7:0] = dat;
        if (pid == 8'h82) m_val[15:8] = dat;
      end
    end
    e.leds = m_led;
    e.nm   = nm;
    @(posedge CLK); #1;
    e.cyc = cyc;
    sbq.push_back(e);
  endtask

  task automatic idle(input string nm, input int n);
    for (int i = 0; i < n; i++) tick(nm, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic chk(input string nm, input string f, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s.%s cyc=%0d got=%h want=%h", nm, f, cyc, got, want);
    end
  endtask

  // Monitor: outputs are valid every cycle, compare on the falling edge.
  always @(negedge CLK) begin
    while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      if (e.cyc < cyc) begin
        total++; bad++;
        $display("FAIL %s.stale cyc=%0d got=%0d want=%0d", e.nm, cyc, cyc, e.cyc);
      end else begin
        chk(e.nm, "leds0", LEDS0, e.leds);
        chk(e.nm, "leds1", LEDS1, e.leds);
        chk(e.nm, "an0",   {4'h0, AN0}, {4'h0, e.an0});
        chk(e.nm, "seg0",  SEG0, e.seg0);
        chk(e.nm, "an1",   {4'h0, AN1}, {4'h0, e.an1});
        chk(e.nm, "seg1",  SEG1, e.seg1);
      end
    end
  end

  initial begin
    bif.IO_STRB = 1'b0; bif.PORT_ID = 8'h00; bif.OUTPUT_DATA = 8'h00;
    // Reset state
    tick("rst", 1'b1, 1'b0, 8'h00, 8'h00);
    tick("rst", 1'b1, 1'b0, 8'h00, 8'h00);
    // LED write and hold
    tick("led_wr", 1'b0, 1'b1, 8'h40, 8'hA5);
    idle("led_hold", 20);
    tick("sseg_lo_wr", 1'b0, 1'b1, 8'h81, 8'h3C);
    idle("after_lo", 3);
    // Unmapped port and unstrobed write
    tick("unmapped", 1'b0, 1'b1, 8'h55, 8'hFF);
    idle("after_unmapped", 4);
    tick("nostrb", 1'b0, 1'b0, 8'h40, 8'hFF);
    idle("after_nostrb", 16);
    // Full scan of 0x1234
    tick("scan_lo", 1'b0, 1'b1, 8'h81, 8'h34);
    tick("scan_hi", 1'b0, 1'b1, 8'h82, 8'h12);
    idle("scan", 34);
    // Leading-zero blanking
    tick("lz_lo", 1'b0, 1'b1, 8'h81, 8'hA0);
    tick("lz_hi", 1'b0, 1'b1, 8'h82, 8'h00);
    idle("lz_a0", 18);
    tick("lz_zero", 1'b0, 1'b1, 8'h81, 8'h00);
    idle("lz_0", 17);
    // Reset during DIG2 with a coincident LED write
    tick("pre_rst", 1'b0, 1'b1, 8'h40, 8'h5A);
    for (int g = 0; g < 16 && ((m_n / 4) % 4) != 2; g++) idle("to_dig2", 1);
    tick("rst_mid", 1'b1, 1'b1, 8'h40, 8'h77);
    tick("rst_mid", 1'b1, 1'b0, 8'h00, 8'h00);
    tick("post_rst", 1'b0, 1'b0, 8'h00, 8'h00);
    idle("post_rst_scan", 8);
    // Drain the scoreboard with a bound
    for (int t = 0; t < 10 && sbq.size() != 0; t++) @(negedge CLK);
    @(negedge CLK);
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
